// File: rtl/axis_stream_source_blkmon.sv
// AXI4-Stream burst source: patterned beats (seed + index), TLAST on final beat, sticky stall monitor.
// Optional pseudo-random bubble insertion when AXIS_SRC_THROTTLE_EN is defined.
module axis_stream_source_blkmon #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    beats_sent,
  output logic                block,
  output logic [DATA_W-1:0]   TDATA,
  output logic [DATA_W/8-1:0] TKEEP,
  output logic                TLAST,
  output logic                TVALID,
  input  logic                TREADY
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [SW-1:0]     stall_cnt;
  logic              hs, last_hs, accept, present;

  assign hs      = TVALID & TREADY;
  assign last_hs = hs & TLAST;
  assign accept  = (state == IDLE) & start;
  assign busy    = (state == SEND);
  assign TKEEP   = '1;
  assign TLAST   = TVALID & (beats_sent == len_q - LEN_W'(1));

`ifdef AXIS_SRC_THROTTLE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11; bit 0 gates presentation of each new beat.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign present = ~lfsr[0];
`else
  assign present = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len != '0) state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      done       <= 1'b0;
      beats_sent <= '0;
      block      <= 1'b0;
      len_q      <= '0;
      TDATA      <= '0;
      TVALID     <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      done <= last_hs | (accept & (len == '0));

      if (accept) begin
        beats_sent <= '0;
        block      <= 1'b0;
        len_q      <= len;
        TDATA      <= seed;
        TVALID     <= (len != '0) & present;
      end else if (state == SEND) begin
        if (hs) begin
          beats_sent <= beats_sent + LEN_W'(1);
          TDATA      <= TDATA + DATA_W'(1);
        end
        // A presented beat stays up until it handshakes.
        if (last_hs)              TVALID <= 1'b0;
        else if (!TVALID || hs)   TVALID <= present;
      end

      // block becomes visible in the same cycle stall_cnt shows STALL_LIMIT.
      if (TVALID && !TREADY) begin
        if (stall_cnt != SW'(STALL_LIMIT)) stall_cnt <= stall_cnt + SW'(1);
        if (stall_cnt >= SW'(STALL_LIMIT - 1)) block <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_source_blkmon.sv
// Directed bench for axis_stream_source_blkmon (STALL_LIMIT=8).
module tb_axis_stream_source_blkmon;

  logic        ap_clk = 1'b0;
  logic        ap_rst, start, busy, done, block, TLAST, TVALID, TREADY;
  logic [15:0] len, beats_sent;
  logic [31:0] seed, TDATA;
  logic [3:0]  TKEEP;
  int compared   = 0;
  int mismatched = 0;

  axis_stream_source_blkmon #(.DATA_W(32), .LEN_W(16), .STALL_LIMIT(8)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .len(len), .seed(seed),
    .busy(busy), .done(done), .beats_sent(beats_sent), .block(block),
    .TDATA(TDATA), .TKEEP(TKEEP), .TLAST(TLAST), .TVALID(TVALID), .TREADY(TREADY)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic launch(input logic [15:0] l, input logic [31:0] s);
    start = 1'b1; len = l; seed = s;
    tick();
    start = 1'b0; len = 16'hDEAD; seed = 32'hBAD0BAD0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; start = 1'b0; len = '0; seed = '0; TREADY = 1'b0;
    tick(); tick();
    ap_rst = 1'b0;
    compared++;
    if ({busy, done, block, TVALID, TLAST} !== 5'b0 || beats_sent !== 16'd0 || TDATA !== 32'd0 || TKEEP !== 4'hF) begin
      mismatched++;
      $display("FAIL reset: busy/done/block/valid/last=%b beats=%0d data=%h keep=%h, want 0/0/0/0/0 0 0 f",
               {busy, done, block, TVALID, TLAST}, beats_sent, TDATA, TKEEP);
    end
  endtask

  task automatic test_basic();
    TREADY = 1'b1;
    launch(16'd4, 32'h10);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (TVALID !== 1'b1 || TDATA !== 32'h10 + i || TLAST !== (i == 3) || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL t1_beat%0d: valid=%b data=%h last=%b busy=%b, want 1 %h %b 1",
                 i, TVALID, TDATA, TLAST, busy, 32'h10 + i, i == 3);
      end
      if (i == 1) begin
        start = 1'b1; len = 16'd9; seed = 32'h999;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    compared++;
    if (done !== 1'b1 || TVALID !== 1'b0 || busy !== 1'b0 || beats_sent !== 16'd4 || block !== 1'b0) begin
      mismatched++;
      $display("FAIL t1_done: done=%b valid=%b busy=%b beats=%0d block=%b, want 1 0 0 4 0",
               done, TVALID, busy, beats_sent, block);
    end
    tick();
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL t1_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_toggle_ready();
    int beat = 0, dones = 0;
    logic [31:0] pd; logic pl, pstall = 1'b0;
    launch(16'd3, 32'h20);
    for (int c = 0; c < 10; c++) begin
      TREADY = (c % 2 == 0);
      if (done) dones++;
      if (pstall) begin
        compared++;
        if (TVALID !== 1'b1 || TDATA !== pd || TLAST !== pl) begin
          mismatched++;
          $display("FAIL t2_hold c%0d: valid=%b data=%h last=%b, want 1 %h %b", c, TVALID, TDATA, TLAST, pd, pl);
        end
      end
      if (TVALID) begin
        compared++;
        if (TDATA !== 32'h20 + beat || TLAST !== (beat == 2)) begin
          mismatched++;
          $display("FAIL t2_beat%0d: data=%h last=%b, want %h %b", beat, TDATA, TLAST, 32'h20 + beat, beat == 2);
        end
        if (TREADY) beat++;
      end
      pstall = TVALID & ~TREADY; pd = TDATA; pl = TLAST;
      tick();
    end
    compared++;
    if (beat !== 3 || dones !== 1 || beats_sent !== 16'd3) begin
      mismatched++;
      $display("FAIL t2_count: beats=%0d dones=%0d beats_sent=%0d, want 3 1 3", beat, dones, beats_sent);
    end
  endtask

  task automatic test_stall_block();
    TREADY = 1'b0;
    launch(16'd2, 32'h30);
    for (int k = 1; k <= 20; k++) begin
      if (k == 8 || k == 9 || k == 20) begin
        compared++;
        if (block !== (k >= 9) || TVALID !== 1'b1 || TDATA !== 32'h30) begin
          mismatched++;
          $display("FAIL t3_stall%0d: block=%b valid=%b data=%h, want %b 1 30", k, block, TVALID, TDATA, k >= 9);
        end
      end
      tick();
    end
    TREADY = 1'b1;
    tick();
    compared++;
    if (TDATA !== 32'h31 || TLAST !== 1'b1 || block !== 1'b1) begin
      mismatched++;
      $display("FAIL t3_beat1: data=%h last=%b block=%b, want 31 1 1", TDATA, TLAST, block);
    end
    tick();
    compared++;
    if (done !== 1'b1 || block !== 1'b1 || beats_sent !== 16'd2) begin
      mismatched++;
      $display("FAIL t3_done: done=%b block=%b beats=%0d, want 1 1 2", done, block, beats_sent);
    end
    tick();
    launch(16'd1, 32'h0);
    compared++;
    if (block !== 1'b0 || TVALID !== 1'b1) begin
      mismatched++;
      $display("FAIL t3_clear: block=%b valid=%b, want 0 1", block, TVALID);
    end
    tick(); tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFFFFFE; exp[1] = 32'hFFFFFFFF; exp[2] = 32'h00000000;
    TREADY = 1'b1;
    launch(16'd3, 32'hFFFFFFFE);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (TVALID !== 1'b1 || TDATA !== exp[i] || TLAST !== (i == 2)) begin
        mismatched++;
        $display("FAIL t4_beat%0d: valid=%b data=%h last=%b, want 1 %h %b", i, TVALID, TDATA, TLAST, exp[i], i == 2);
      end
      tick();
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL t4_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_zero_len_and_reset();
    TREADY = 1'b1;
    launch(16'd0, 32'h55);
    compared++;
    if (TVALID !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || beats_sent !== 16'd0) begin
      mismatched++;
      $display("FAIL t5_zero: valid=%b done=%b busy=%b beats=%0d, want 0 1 0 0", TVALID, done, busy, beats_sent);
    end
    tick();
    launch(16'd5, 32'h100);
    tick(); tick();
    compared++;
    if (TDATA !== 32'h102 || TVALID !== 1'b1) begin
      mismatched++;
      $display("FAIL t5_beat2: data=%h valid=%b, want 102 1", TDATA, TVALID);
    end
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    compared++;
    if (TVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beats_sent !== 16'd0) begin
      mismatched++;
      $display("FAIL t5_rst: valid=%b busy=%b done=%b beats=%0d, want 0 0 0 0", TVALID, busy, done, beats_sent);
    end
    tick();
    compared++;
    if (done !== 1'b0 || TVALID !== 1'b0) begin
      mismatched++;
      $display("FAIL t5_nodone: done=%b valid=%b, want 0 0", done, TVALID);
    end
    launch(16'd2, 32'h200);
    compared++;
    if (TVALID !== 1'b1 || TDATA !== 32'h200) begin
      mismatched++;
      $display("FAIL t5_restart: valid=%b data=%h, want 1 200", TVALID, TDATA);
    end
    tick(); tick();
    compared++;
    if (done !== 1'b1 || beats_sent !== 16'd2) begin
      mismatched++;
      $display("FAIL t5_restart_done: done=%b beats=%0d, want 1 2", done, beats_sent);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    TREADY = 1'b1;
    launch(16'd1, 32'h40);
    tick();
    // start during the done cycle must be ignored
    launch(16'd2, 32'h50);
    compared++;
    if (TVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_ignore: valid=%b busy=%b done=%b, want 0 0 0", TVALID, busy, done);
    end
    launch(16'd2, 32'h60);
    compared++;
    if (TVALID !== 1'b1 || TDATA !== 32'h60 || beats_sent !== 16'd0) begin
      mismatched++;
      $display("FAIL b2b_next: valid=%b data=%h beats=%0d, want 1 60 0", TVALID, TDATA, beats_sent);
    end
    tick(); tick(); tick();
  endtask

`ifdef AXIS_SRC_THROTTLE_EN
  task automatic test_throttle();
    int beat = 0, bubbles = 0;
    bit seen_done = 0;
    TREADY = 1'b1;
    launch(16'd64, 32'h0);
    for (int c = 0; c < 1000 && !seen_done; c++) begin
      if (done) seen_done = 1;
      else if (TVALID) begin
        compared++;
        if (TDATA !== 32'(beat) || TLAST !== (beat == 63)) begin
          mismatched++;
          $display("FAIL t6_beat%0d: data=%h last=%b", beat, TDATA, TLAST);
        end
        beat++;
      end else if (busy) bubbles++;
      tick();
    end
    compared++;
    if (!seen_done || beat != 64 || bubbles == 0 || block !== 1'b0) begin
      mismatched++;
      $display("FAIL t6_summary: done=%0d beats=%0d bubbles=%0d block=%b, want 1 64 >0 0", seen_done, beat, bubbles, block);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AXIS_SRC_THROTTLE_EN
    test_throttle();
`else
    test_basic();
    test_toggle_ready();
    test_stall_block();
    test_wrap();
    test_zero_len_and_reset();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
